cnt_seq_monitor: RTL and testbench
==================================

Name: cnt_seq_monitor

Overview:
- Downstream checker for the 4-bit up/down loadable counter. It samples the counter's control inputs (cnt_rst, load_en, up_down, data) and its output q every clock.
- It predicts the next count, flags any deviation, and counts wrap-around events (15->0 counting up, 0->15 counting down).
- It sits beside the counter in the datapath as an always-on integrity and event monitor feeding status logic.

Parameters:
- WRAP_W, 8, width of wrap event counter(s).
- WRAP_LIMIT, 16, wrap_count value that raises limit_pulse; must be in 1..2^WRAP_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset of the monitor.
- mon_en  input  1  monitor enable; 0 forces SYNC.
- clr  input  1  synchronous clear of sticky flags and counters.
- cnt_rst  input  1  copy of the counter's synchronous reset.
- load_en  input  1  copy of the counter's load enable.
- up_down  input  1  copy of the counter's direction; 1 = up, 0 = down.
- data  input  4  copy of the counter's load value.
- q_in  input  4  counter output q.
- wrap_pulse  output  1  one-cycle pulse per verified wrap.
- wrap_count  output  WRAP_W  verified wraps since reset/clr; saturating.
- limit_pulse  output  1  one-cycle pulse when wrap_count becomes WRAP_LIMIT.
- mismatch  output  1  sticky fault flag.
- fault_q  output  4  q_in value captured at the first mismatch.
- fault_exp  output  4  expected value at the first mismatch.

Behaviour:
- Reset (rst=1, asynchronous): state=SYNC, expectation register and pending-wrap flag cleared, all outputs 0.
- Counter model (priority high to low):
  - cnt_rst -> next value 0.
  - load_en -> next value data.
  - up_down=1 -> q+1 mod 16.
  - up_down=0 -> q-1 mod 16.
- Prediction: at edge k the monitor registers exp = model(q_in, controls sampled at edge k). It also sets wrap_pend=1 iff the model took the count branch and either (up_down=1, q_in=15) or (up_down=0, q_in=0).
- Check: at edge k+1 it compares q_in against exp. Outputs are registered, so a result is visible in the cycle after edge k+1 (1-cycle latency from the counter updating).
- States:
  - SYNC: no valid expectation, no checking. If mon_en=1 and clr=0 at an edge, capture the prediction and go to TRACK.
  - TRACK: each edge compares, then captures a new prediction.
    - Match and wrap_pend: wrap_pulse=1; wrap_count+1, saturating at all-ones; limit_pulse=1 on the edge where wrap_count becomes exactly WRAP_LIMIT.
    - Mismatch: mismatch=1, fault_q=q_in, fault_exp=exp, go to FAULT; no wrap counted on that edge.
    - mon_en=0: go to SYNC and discard the expectation; counters are held.
  - FAULT: no checking or counting. mismatch, fault_q, fault_exp and wrap_count are held.
- clr=1 at an edge, in any state:
  - wrap_count, mismatch, fault_q and fault_exp go to 0; pulses go to 0; next state is SYNC.
  - clr overrides a same-edge mismatch or wrap.
- wrap_pulse and limit_pulse are 0 on every edge not listed above.
- A load of 15 or 0 followed by a count step still counts as a wrap when that step crosses the boundary.
- A cnt_rst or load is never itself a wrap, even when it moves q between 15 and 0.
- rst asserted mid-operation aborts immediately; any pulse in flight is dropped.

Optional Feature:
- Macro: CNT_MON_DIR_STATS_EN.
- Defined: adds outputs wrap_up_count[WRAP_W] and wrap_dn_count[WRAP_W], each saturating.
  - They count verified up-wraps (15->0) and down-wraps (0->15) respectively.
  - Same reset, clr and FAULT-freeze rules as wrap_count; wrap_count equals their sum until saturation.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Power-up: rst=1, then rst=0 with mon_en=0 -> all outputs 0, state SYNC, no pulses regardless of q_in.
- Up count: mon_en=1, cnt_rst=0, load_en=0, up_down=1, counter from 0 for 34 cycles -> wrap_pulse on each 15->0 (2 pulses), wrap_count=2, mismatch=0.
- Down count with load: load data=4'h2, then up_down=0 for 3 cycles (2,1,0,15) -> exactly one wrap_pulse on 0->15; the load itself produces no pulse; wrap_count increments by 1.
- Fault injection: while tracking q=5 counting up, force q_in=9 instead of 6 -> mismatch=1, fault_q=9, fault_exp=6; wrap_count frozen. Then clr=1 -> all cleared, SYNC, and tracking resumes after the next edge.
- Limit/saturation: WRAP_LIMIT=3, WRAP_W=2, continuous up count -> limit_pulse once on the 3rd wrap; wrap_count stays 3 with no further limit_pulse.
- Simultaneous events: cnt_rst=1 with load_en=1 and data=4'hA at q=15, up_down=1 -> expected 0, no wrap_pulse, no mismatch. Also: clr asserted on a wrap edge -> wrap_count=0, no pulse.

Source files
------------

// File: rtl/cnt_seq_monitor.sv
// cnt_seq_monitor: integrity and wrap-event monitor for a 4-bit up/down loadable counter.
//
// Samples the counter's controls and output every clock, predicts the next count,
// latches the first deviation and counts verified wrap-arounds (15->0 up, 0->15 down).
//
// Optional build macro: CNT_MON_DIR_STATS_EN adds per-direction wrap counters.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   mon_en         monitor enable (0 forces SYNC)
//   clr            synchronous clear of sticky flags and counters
//   cnt_rst        copy of counter synchronous reset
//   load_en, data  copy of counter load enable and load value
//   up_down        copy of counter direction (1 = up)
//   q_in           counter output
//   wrap_pulse     one-cycle pulse per verified wrap
//   wrap_count     saturating count of verified wraps
//   limit_pulse    one-cycle pulse when wrap_count becomes WRAP_LIMIT
//   mismatch       sticky fault flag
//   fault_q        q_in captured at the first mismatch
//   fault_exp      expected value at the first mismatch
//   wrap_up_count  (macro only) saturating count of verified 15->0 wraps
//   wrap_dn_count  (macro only) saturating count of verified 0->15 wraps
module cnt_seq_monitor #(
    parameter int unsigned WRAP_W     = 8,
    parameter int unsigned WRAP_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mon_en,
    input  logic              clr,
    input  logic              cnt_rst,
    input  logic              load_en,
    input  logic              up_down,
    input  logic [3:0]        data,
    input  logic [3:0]        q_in,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              limit_pulse,
    output logic              mismatch,
    output logic [3:0]        fault_q,
    output logic [3:0]        fault_exp
`ifdef CNT_MON_DIR_STATS_EN
    ,
    output logic [WRAP_W-1:0] wrap_up_count,
    output logic [WRAP_W-1:0] wrap_dn_count
`else
    // per-direction wrap counters are not built
`endif
);

    localparam logic [WRAP_W-1:0] CNT_ONE   = WRAP_W'(1);
    localparam logic [WRAP_W-1:0] CNT_MAX   = '1;
    // wrap_count value one step before the limit is reached
    localparam logic [WRAP_W-1:0] LIMIT_PRE = WRAP_W'(WRAP_LIMIT - 1);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] exp_q;
    logic       wrap_pend;

    logic [3:0] pred_q;
    logic       pred_wrap;

    // Counter model: cnt_rst over load over count.
    always_comb begin
        pred_q    = q_in;
        pred_wrap = 1'b0;
        if (cnt_rst) begin
            pred_q = 4'h0;
        end else if (load_en) begin
            pred_q = data;
        end else if (up_down) begin
            pred_q    = q_in + 4'h1;
            pred_wrap = (q_in == 4'hF);
        end else begin
            pred_q    = q_in - 4'h1;
            pred_wrap = (q_in == 4'h0);
        end
    end

`ifdef CNT_MON_DIR_STATS_EN
    // direction of the pending wrap (1 = up)
    logic wrap_dir;
`endif

    // Monitor FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SYNC;
            exp_q       <= 4'h0;
            wrap_pend   <= 1'b0;
            wrap_pulse  <= 1'b0;
            wrap_count  <= '0;
            limit_pulse <= 1'b0;
            mismatch    <= 1'b0;
            fault_q     <= 4'h0;
            fault_exp   <= 4'h0;
`ifdef CNT_MON_DIR_STATS_EN
            wrap_dir      <= 1'b0;
            wrap_up_count <= '0;
            wrap_dn_count <= '0;
`endif
        end else begin
            wrap_pulse  <= 1'b0;
            limit_pulse <= 1'b0;
            if (clr) begin
                // clr wins over any same-edge mismatch or wrap
                state      <= SYNC;
                exp_q      <= 4'h0;
                wrap_pend  <= 1'b0;
                wrap_count <= '0;
                mismatch   <= 1'b0;
                fault_q    <= 4'h0;
                fault_exp  <= 4'h0;
`ifdef CNT_MON_DIR_STATS_EN
                wrap_dir      <= 1'b0;
                wrap_up_count <= '0;
                wrap_dn_count <= '0;
`endif
            end else begin
                case (state)
                    SYNC: begin
                        if (mon_en) begin
                            exp_q     <= pred_q;
                            wrap_pend <= pred_wrap;
`ifdef CNT_MON_DIR_STATS_EN
                            wrap_dir  <= up_down;
`endif
                            state     <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (!mon_en) begin
                            // expectation discarded, counters held
                            exp_q     <= 4'h0;
                            wrap_pend <= 1'b0;
                            state     <= SYNC;
                        end else if (q_in != exp_q) begin
                            mismatch  <= 1'b1;
                            fault_q   <= q_in;
                            fault_exp <= exp_q;
                            wrap_pend <= 1'b0;
                            state     <= FAULT;
                        end else begin
                            exp_q     <= pred_q;
                            wrap_pend <= pred_wrap;
`ifdef CNT_MON_DIR_STATS_EN
                            wrap_dir  <= up_down;
`endif
                            if (wrap_pend) begin
                                wrap_pulse <= 1'b1;
                                if (wrap_count != CNT_MAX) begin
                                    wrap_count <= wrap_count + CNT_ONE;
                                    if (wrap_count == LIMIT_PRE) begin
                                        limit_pulse <= 1'b1;
                                    end
                                end
`ifdef CNT_MON_DIR_STATS_EN
                                if (wrap_dir) begin
                                    if (wrap_up_count != CNT_MAX) begin
                                        wrap_up_count <= wrap_up_count + CNT_ONE;
                                    end
                                end else begin
                                    if (wrap_dn_count != CNT_MAX) begin
                                        wrap_dn_count <= wrap_dn_count + CNT_ONE;
                                    end
                                end
`endif
                            end
                        end
                    end
                    FAULT: begin
                        // frozen until clr or rst
                    end
                    default: begin
                        state <= SYNC;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnt_seq_monitor.sv
module tb_cnt_seq_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mon_en = 1'b0;
    logic       clr = 1'b0;
    logic       cnt_rst = 1'b0;
    logic       load_en = 1'b0;
    logic       up_down = 1'b1;
    logic [3:0] data = 4'h0;
    logic [3:0] q_in = 4'h0;

    logic       wrap_pulse, limit_pulse, mismatch;
    logic [7:0] wrap_count;
    logic [3:0] fault_q, fault_exp;
    logic       s_wrap_pulse, s_limit_pulse, s_mismatch;
    logic [1:0] s_wrap_count;
    logic [3:0] s_fault_q, s_fault_exp;
`ifdef CNT_MON_DIR_STATS_EN
    logic [7:0] wrap_up_count, wrap_dn_count;
    logic [1:0] s_wrap_up_count, s_wrap_dn_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cnt_seq_monitor u_dut (
        .clk(clk), .rst(rst), .mon_en(mon_en), .clr(clr), .cnt_rst(cnt_rst),
        .load_en(load_en), .up_down(up_down), .data(data), .q_in(q_in),
        .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .limit_pulse(limit_pulse),
        .mismatch(mismatch), .fault_q(fault_q), .fault_exp(fault_exp)
`ifdef CNT_MON_DIR_STATS_EN
        , .wrap_up_count(wrap_up_count), .wrap_dn_count(wrap_dn_count)
`endif
    );

    cnt_seq_monitor #(.WRAP_W(2), .WRAP_LIMIT(3)) u_sml (
        .clk(clk), .rst(rst), .mon_en(mon_en), .clr(clr), .cnt_rst(cnt_rst),
        .load_en(load_en), .up_down(up_down), .data(data), .q_in(q_in),
        .wrap_pulse(s_wrap_pulse), .wrap_count(s_wrap_count), .limit_pulse(s_limit_pulse),
        .mismatch(s_mismatch), .fault_q(s_fault_q), .fault_exp(s_fault_exp)
`ifdef CNT_MON_DIR_STATS_EN
        , .wrap_up_count(s_wrap_up_count), .wrap_dn_count(s_wrap_dn_count)
`endif
    );

    // Reference: counter behaviour and monitor rules; index 0 = default instance, 1 = small.
    int cq = 0;
    int m_mode = 0;                // 0 sync, 1 tracking, 2 faulted
    int s_q, s_d;
    bit s_cr, s_ld, s_ud;
    int m_wc[2], m_up[2], m_dn[2];
    bit m_wp[2], m_lp[2];
    int m_max[2] = '{255, 3};
    int m_lim[2] = '{16, 3};
    bit m_mis;
    int m_fq, m_fe;

    function automatic int next_count(int q, bit cr, bit ld, bit ud, int d);
        if (cr) return 0;
        if (ld) return d;
        if (ud) return (q + 1) % 16;
        return (q + 15) % 16;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_mis = 0; m_fq = 0; m_fe = 0;
        for (int i = 0; i < 2; i++) begin
            m_wc[i] = 0; m_up[i] = 0; m_dn[i] = 0; m_wp[i] = 0; m_lp[i] = 0;
        end
    endtask

    task automatic save_sample();
        s_q = int'(q_in); s_cr = cnt_rst; s_ld = load_en; s_ud = up_down; s_d = int'(data);
    endtask

    task automatic model_edge();
        int e;
        bit crossed;
        for (int i = 0; i < 2; i++) begin m_wp[i] = 0; m_lp[i] = 0; end
        if (clr) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (mon_en) begin save_sample(); m_mode = 1; end
        end else if (m_mode == 1) begin
            if (!mon_en) begin
                m_mode = 0;
            end else begin
                e = next_count(s_q, s_cr, s_ld, s_ud, s_d);
                if (int'(q_in) != e) begin
                    m_mis = 1; m_fq = int'(q_in); m_fe = e; m_mode = 2;
                end else begin
                    crossed = !s_cr && !s_ld && ((s_ud && s_q == 15) || (!s_ud && s_q == 0));
                    if (crossed) begin
                        for (int i = 0; i < 2; i++) begin
                            m_wp[i] = 1;
                            if (m_wc[i] < m_max[i]) begin
                                m_wc[i]++;
                                if (m_wc[i] == m_lim[i]) m_lp[i] = 1;
                            end
                            if (s_ud && m_up[i] < m_max[i]) m_up[i]++;
                            if (!s_ud && m_dn[i] < m_max[i]) m_dn[i]++;
                        end
                    end
                    save_sample();
                end
            end
        end
    endtask

    // One clock: model and counter advance on the edge; outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        cq = next_count(cq, cnt_rst, load_en, up_down, int'(data));
        #1;
        q_in = 4'(cq);
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wrap_pulse, limit_pulse, mismatch, wrap_count, fault_q, fault_exp} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got wp=%0b lp=%0b mis=%0b wc=%0d fq=%0d fe=%0d want all 0",
                     wrap_pulse, limit_pulse, mismatch, wrap_count, fault_q, fault_exp);
        end
        rst = 1'b0;
        mon_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            q_in = 4'($urandom_range(0, 15));
            up_down = 1'($urandom);
            tick();
            checks++;
            if ({wrap_pulse, limit_pulse, mismatch, wrap_count, s_wrap_pulse} !== 12'd0) begin
                failures++;
                $display("FAIL idle_sync cyc=%0d got wp=%0b lp=%0b mis=%0b wc=%0d want 0",
                         i, wrap_pulse, limit_pulse, mismatch, wrap_count);
            end
        end
    endtask

    task automatic test_up_count();
        int p = 0;
        mon_en = 1'b1; up_down = 1'b1; load_en = 1'b0; cnt_rst = 1'b1;
        tick();
        cnt_rst = 1'b0;
        for (int i = 0; i < 34; i++) begin
            tick();
            if (wrap_pulse === 1'b1) p++;
        end
        checks++;
        if (p != 2) begin failures++; $display("FAIL up_pulses got %0d want 2", p); end
        checks++;
        if (wrap_count !== 8'd2 || s_wrap_count !== 2'd2) begin
            failures++;
            $display("FAIL up_wrap_count got %0d/%0d want 2/2", wrap_count, s_wrap_count);
        end
        checks++;
        if (mismatch !== 1'b0) begin failures++; $display("FAIL up_mismatch got %0b want 0", mismatch); end
    endtask

    task automatic test_down_load();
        int p;
        load_en = 1'b1; data = 4'h2; up_down = 1'b0;
        tick();
        load_en = 1'b0;
        p = (wrap_pulse === 1'b1) ? 1 : 0;
        checks++;
        if (p != 0) begin failures++; $display("FAIL load_pulse got %0d want 0", p); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wrap_pulse === 1'b1) p++;
        end
        checks++;
        if (p != 1) begin failures++; $display("FAIL down_pulses got %0d want 1", p); end
        checks++;
        if (wrap_count !== 8'd3 || mismatch !== 1'b0) begin
            failures++;
            $display("FAIL down_wrap_count got wc=%0d mis=%0b want wc=3 mis=0", wrap_count, mismatch);
        end
    endtask

    task automatic test_fault();
        int p = 0;
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (wrap_count !== 8'd0 || mismatch !== 1'b0) begin
            failures++; $display("FAIL clr_counts got wc=%0d mis=%0b want 0", wrap_count, mismatch);
        end
        up_down = 1'b1; cnt_rst = 1'b1; tick(); cnt_rst = 1'b0;
        repeat (6) tick();
        q_in = 4'h9;               // counter is at 6
        tick();
        checks++;
        if (mismatch !== 1'b1 || fault_q !== 4'h9 || fault_exp !== 4'h6) begin
            failures++;
            $display("FAIL fault_capture got mis=%0b fq=%0d fe=%0d want 1/9/6", mismatch, fault_q, fault_exp);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wrap_pulse === 1'b1) p++;
        end
        checks++;
        if (p != 0 || wrap_count !== 8'd0 || mismatch !== 1'b1 || fault_q !== 4'h9) begin
            failures++;
            $display("FAIL fault_freeze got pulses=%0d wc=%0d mis=%0b fq=%0d want 0/0/1/9",
                     p, wrap_count, mismatch, fault_q);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (mismatch !== 1'b0 || fault_q !== 4'h0 || fault_exp !== 4'h0) begin
            failures++;
            $display("FAIL fault_clear got mis=%0b fq=%0d fe=%0d want 0", mismatch, fault_q, fault_exp);
        end
        p = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wrap_pulse === 1'b1) p++;
        end
        checks++;
        if (mismatch !== 1'b0 || p != 1 || wrap_count !== 8'd1) begin
            failures++;
            $display("FAIL resume_track got mis=%0b pulses=%0d wc=%0d want 0/1/1", mismatch, p, wrap_count);
        end
    endtask

    task automatic test_limit();
        int lb = 0, ls = 0;
        clr = 1'b1; tick(); clr = 1'b0;
        up_down = 1'b1; cnt_rst = 1'b1; tick(); cnt_rst = 1'b0;
        for (int i = 0; i < 82; i++) begin
            tick();
            if (limit_pulse === 1'b1) lb++;
            if (s_limit_pulse === 1'b1) ls++;
        end
        checks++;
        if (ls != 1 || s_wrap_count !== 2'd3) begin
            failures++; $display("FAIL small_limit got lp=%0d wc=%0d want 1/3", ls, s_wrap_count);
        end
        checks++;
        if (lb != 0 || wrap_count !== 8'd5) begin
            failures++; $display("FAIL big_pre_limit got lp=%0d wc=%0d want 0/5", lb, wrap_count);
        end
        for (int i = 0; i < 176; i++) begin
            tick();
            if (limit_pulse === 1'b1) lb++;
            if (s_limit_pulse === 1'b1) ls++;
        end
        checks++;
        if (lb != 1 || wrap_count !== 8'd16) begin
            failures++; $display("FAIL big_limit got lp=%0d wc=%0d want 1/16", lb, wrap_count);
        end
        checks++;
        if (ls != 1 || s_wrap_count !== 2'd3 || s_mismatch !== 1'b0) begin
            failures++; $display("FAIL small_saturate got lp=%0d wc=%0d want 1/3", ls, s_wrap_count);
        end
    endtask

    task automatic test_simultaneous();
        int p = 0;
        up_down = 1'b1; load_en = 1'b1; data = 4'hF; tick();
        cnt_rst = 1'b1; load_en = 1'b1; data = 4'hA; tick();
        cnt_rst = 1'b0; load_en = 1'b0;
        if (wrap_pulse === 1'b1) p++;
        tick();
        if (wrap_pulse === 1'b1) p++;
        tick();
        if (wrap_pulse === 1'b1) p++;
        checks++;
        if (p != 0 || mismatch !== 1'b0 || wrap_count !== 8'd16) begin
            failures++;
            $display("FAIL rst_load_at_15 got pulses=%0d mis=%0b wc=%0d want 0/0/16", p, mismatch, wrap_count);
        end
        load_en = 1'b1; data = 4'hE; tick();
        load_en = 1'b0; tick(); tick();
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (wrap_pulse !== 1'b0 || wrap_count !== 8'd0 || s_wrap_count !== 2'd0) begin
            failures++;
            $display("FAIL clr_on_wrap got wp=%0b wc=%0d want 0/0", wrap_pulse, wrap_count);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        clr = 1'b1; tick(); clr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            mon_en  = ($urandom_range(0, 15) != 0);
            clr     = ($urandom_range(0, 63) == 0);
            cnt_rst = ($urandom_range(0, 15) == 0);
            load_en = ($urandom_range(0, 7) == 0);
            up_down = 1'($urandom);
            data    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) q_in = q_in ^ 4'($urandom_range(1, 15));
            tick();
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #2;
                model_reset();
                checks++;
                if ({wrap_pulse, limit_pulse, mismatch, wrap_count, s_wrap_pulse} !== 12'd0) begin
                    failures++;
                    $display("FAIL mid_reset n=%0d got wp=%0b lp=%0b mis=%0b wc=%0d want 0",
                             n, wrap_pulse, limit_pulse, mismatch, wrap_count);
                end
                rst = 1'b0;
            end
            checks++;
            if (wrap_pulse !== m_wp[0] || limit_pulse !== m_lp[0] || wrap_count !== 8'(m_wc[0]) ||
                mismatch !== m_mis || fault_q !== 4'(m_fq) || fault_exp !== 4'(m_fe) ||
                s_wrap_pulse !== m_wp[1] || s_limit_pulse !== m_lp[1] ||
                s_wrap_count !== 2'(m_wc[1]) || s_mismatch !== m_mis) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random n=%0d got wp=%0b lp=%0b wc=%0d mis=%0b fq=%0d fe=%0d swc=%0d slp=%0b want wp=%0b lp=%0b wc=%0d mis=%0b fq=%0d fe=%0d swc=%0d slp=%0b",
                             n, wrap_pulse, limit_pulse, wrap_count, mismatch, fault_q, fault_exp,
                             s_wrap_count, s_limit_pulse, m_wp[0], m_lp[0], m_wc[0], m_mis, m_fq,
                             m_fe, m_wc[1], m_lp[1]);
                bad++;
            end
`ifdef CNT_MON_DIR_STATS_EN
            checks++;
            if (wrap_up_count !== 8'(m_up[0]) || wrap_dn_count !== 8'(m_dn[0]) ||
                s_wrap_up_count !== 2'(m_up[1]) || s_wrap_dn_count !== 2'(m_dn[1])) begin
                failures++;
                if (bad < 10)
                    $display("FAIL dir_stats n=%0d got up=%0d dn=%0d want up=%0d dn=%0d",
                             n, wrap_up_count, wrap_dn_count, m_up[0], m_dn[0]);
                bad++;
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_load();
        test_fault();
        test_limit();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
